// File: rtl/pwm_deadtime_pkg.sv
// Shared state encoding and defaults for the dead-band insertion stage.
package pwm_deadtime_pkg;

  localparam int PWM_DT_DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    OFF,
    LOW_ON,
    DT_RISE,
    HIGH_ON,
    DT_FALL
  } pwm_dt_state_e;

  // Drive pattern {H,L} for a state; every state other than the two ON states is dead.
  function automatic logic [1:0] drv_of(pwm_dt_state_e s);
    logic [1:0] d;
    d = 2'b00;
    if (s == HIGH_ON) d = 2'b10;
    if (s == LOW_ON)  d = 2'b01;
    return d;
  endfunction

endpackage

// File: rtl/pwm_deadtime_if.sv
// Control, raw PWM and complementary drive bundle of pwm_deadtime.
// Polarity inputs exist only when PWM_DEADTIME_POL_EN is defined.
interface pwm_deadtime_if
  import pwm_deadtime_pkg::*;
#(
  parameter int CHNL_NUM = 4,
  parameter int DT_WIDTH = PWM_DT_DEF_WIDTH
);
  logic                en_i;
  logic [DT_WIDTH-1:0] dt_rise_i;
  logic [DT_WIDTH-1:0] dt_fall_i;
  logic [CHNL_NUM-1:0] pwm_i;
  logic [CHNL_NUM-1:0] pwm_h_o;
  logic [CHNL_NUM-1:0] pwm_l_o;
  logic [CHNL_NUM-1:0] dt_busy_o;
`ifdef PWM_DEADTIME_POL_EN
  logic [CHNL_NUM-1:0] pol_h_i;
  logic [CHNL_NUM-1:0] pol_l_i;
`endif

  modport master (
`ifdef PWM_DEADTIME_POL_EN
    output pol_h_i, output pol_l_i,
`endif
    output en_i, output dt_rise_i, output dt_fall_i, output pwm_i,
    input  pwm_h_o, input pwm_l_o, input dt_busy_o
  );

  modport slave (
`ifdef PWM_DEADTIME_POL_EN
    input  pol_h_i, input pol_l_i,
`endif
    input  en_i, input dt_rise_i, input dt_fall_i, input pwm_i,
    output pwm_h_o, output pwm_l_o, output dt_busy_o
  );
endinterface

// File: rtl/pwm_deadtime_chnl.sv
// One channel: FSM plus dead-band counter turning sampled PWM into an H/L pair.
// Latency: 1 clock from in_q to registered drive. No backpressure; runs every clock.
// Counter loads on DT entry only, so dead-time inputs changing mid-band are ignored.
module pwm_deadtime_chnl
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_WIDTH = PWM_DT_DEF_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                in_q,
  input  logic [DT_WIDTH-1:0] dt_rise_i,
  input  logic [DT_WIDTH-1:0] dt_fall_i,
  output logic                h,
  output logic                l,
  output logic                busy
);

  pwm_dt_state_e       state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                busy_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
      h       <= 1'b0;
      l       <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      {h, l}  <= drv_of(state_d);
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    case (state_q)
      OFF, LOW_ON: begin
        if (in_q) begin
          state_d = DT_RISE;
          cnt_d   = dt_rise_i;
        end else begin
          state_d = LOW_ON;
        end
      end
      // Input reverting before expiry returns to the side that was already driven.
      DT_RISE: begin
        if (!in_q)              state_d = LOW_ON;
        else if (cnt_q == '0)   state_d = HIGH_ON;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      HIGH_ON: begin
        if (!in_q) begin
          state_d = DT_FALL;
          cnt_d   = dt_fall_i;
        end
      end
      DT_FALL: begin
        if (in_q)               state_d = HIGH_ON;
        else if (cnt_q == '0)   state_d = LOW_ON;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = OFF;
    endcase
    if (!en_i) begin
      state_d = OFF;
      cnt_d   = '0;
    end
    busy_d = (state_d == DT_RISE) || (state_d == DT_FALL);
  end

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-band insertion top: samples raw PWM once, fans out per-channel FSMs, applies polarity.
// Latency: 2 clocks from a pwm_i edge to the first drive change. No backpressure.
// PWM_DEADTIME_POL_EN adds per-output inversion after the registered drive.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int CHNL_NUM = 4,
  parameter int DT_WIDTH = PWM_DT_DEF_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pwm_deadtime_if.slave  bus
);

  logic [CHNL_NUM-1:0] in_q;
  logic [CHNL_NUM-1:0] h;
  logic [CHNL_NUM-1:0] l;
  logic [CHNL_NUM-1:0] busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) in_q <= '0;
    else       in_q <= bus.pwm_i;
  end

  for (genvar n = 0; n < CHNL_NUM; n++) begin : g_chnl
    pwm_deadtime_chnl #(
      .DT_WIDTH (DT_WIDTH)
    ) u_chnl (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (bus.en_i),
      .in_q      (in_q[n]),
      .dt_rise_i (bus.dt_rise_i),
      .dt_fall_i (bus.dt_fall_i),
      .h         (h[n]),
      .l         (l[n]),
      .busy      (busy[n])
    );
  end

  assign bus.dt_busy_o = busy;

`ifdef PWM_DEADTIME_POL_EN
  // Inversion sits after the dead-band logic, so the no-overlap guarantee is on h/l.
  assign bus.pwm_h_o = h ^ bus.pol_h_i;
  assign bus.pwm_l_o = l ^ bus.pol_l_i;
`else
  assign bus.pwm_h_o = h;
  assign bus.pwm_l_o = l;
`endif

endmodule
